// File: rtl/inbuf_line_sched.sv
// Input-buffer line scheduler: fetches lines from the data FIFO into a 2-entry
// prefetch buffer and presents each line to the encoding engine for M uses.
module inbuf_line_sched #(
   parameter int unsigned M_MAX      = 128,
   parameter int unsigned DATA_W     = 512,
   parameter int unsigned LINE_CNT_W = 16,
   localparam int unsigned MW        = $clog2(M_MAX + 1),
   localparam int unsigned UW        = $clog2(M_MAX)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  eng_rst,
   input  logic                  start,
   input  logic [MW-1:0]         cfg_m,
   input  logic [LINE_CNT_W-1:0] cfg_line_num,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err,
   output logic                  underrun_err,
   output logic                  fifo_rd_rq,
   input  logic                  fifo_empty,
   input  logic [DATA_W-1:0]     fifo_rd_data,
   output logic [DATA_W-1:0]     line_data,
   output logic                  line_val,
   output logic                  line_last_use,
   input  logic                  eng_data_used
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   logic [MW-1:0]         r_m_q;
   logic [LINE_CNT_W-1:0] r_n_q;
   logic [LINE_CNT_W-1:0] r_lines_req;
   logic [LINE_CNT_W-1:0] r_lines_done;
   logic [UW-1:0]         r_use_cnt;
   logic [1:0]            r_occ;
   logic                  r_head;
   logic                  r_inflight;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_cfg_err;
   logic                  r_underrun;
   logic [DATA_W-1:0]     r_buf [2];

   logic                  w_line_val;
   logic                  w_last_use;
   logic                  w_use;
   logic                  w_pop;
   logic                  w_rd_rq;
   logic                  w_cfg_ok;
   logic                  w_wr_idx;
   logic [UW-1:0]         w_m_last;
   logic [LINE_CNT_W-1:0] w_lines_done_nx;

   assign w_m_last        = UW'(r_m_q - MW'(1));
   assign w_line_val      = (r_occ != 2'd0);
   assign w_last_use      = w_line_val & (r_use_cnt == w_m_last);
   assign w_use           = eng_data_used & w_line_val;
   assign w_pop           = w_use & w_last_use;
   assign w_cfg_ok        = (cfg_m >= MW'(2)) & (cfg_m <= MW'(M_MAX)) & (cfg_line_num != '0);
   assign w_wr_idx        = r_head ^ r_occ[0];
   assign w_lines_done_nx = r_lines_done + LINE_CNT_W'(1);

   // Request only when a slot is free counting the line already in flight
   assign w_rd_rq = (r_state == S_RUN) & ~fifo_empty & (r_lines_req < r_n_q)
                  & ((r_occ + {1'b0, r_inflight}) < 2'd2);

   // Prefetch storage; data returning after a soft reset is dropped
   always_ff @(posedge clk) begin
      if (r_inflight && !eng_rst) begin
         r_buf[w_wr_idx] <= fifo_rd_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_m_q        <= '0;
         r_n_q        <= '0;
         r_lines_req  <= '0;
         r_lines_done <= '0;
         r_use_cnt    <= '0;
         r_occ        <= '0;
         r_head       <= 1'b0;
         r_inflight   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_cfg_err    <= 1'b0;
         r_underrun   <= 1'b0;
      end else if (eng_rst) begin
         r_state      <= S_IDLE;
         r_m_q        <= '0;
         r_n_q        <= '0;
         r_lines_req  <= '0;
         r_lines_done <= '0;
         r_use_cnt    <= '0;
         r_occ        <= '0;
         r_head       <= 1'b0;
         r_inflight   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_cfg_err    <= 1'b0;
         r_underrun   <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_cfg_err  <= 1'b0;
         r_underrun <= eng_data_used & ~w_line_val;
         r_inflight <= w_rd_rq;

         if (w_rd_rq) begin
            r_lines_req <= r_lines_req + LINE_CNT_W'(1);
         end

         // Simultaneous write and pop leave occupancy unchanged
         unique case ({r_inflight, w_pop})
            2'b10:   r_occ <= r_occ + 2'd1;
            2'b01:   r_occ <= r_occ - 2'd1;
            default: r_occ <= r_occ;
         endcase

         if (w_use) begin
            r_use_cnt <= w_last_use ? '0 : r_use_cnt + UW'(1);
         end
         if (w_pop) begin
            r_head       <= ~r_head;
            r_lines_done <= w_lines_done_nx;
         end

         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_cfg_ok) begin
                     r_state      <= S_RUN;
                     r_busy       <= 1'b1;
                     r_m_q        <= cfg_m;
                     r_n_q        <= cfg_line_num;
                     r_lines_req  <= '0;
                     r_lines_done <= '0;
                     r_use_cnt    <= '0;
                  end else begin
                     r_cfg_err <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (w_pop && (w_lines_done_nx == r_n_q)) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy          = r_busy;
   assign done          = r_done;
   assign cfg_err       = r_cfg_err;
   assign underrun_err  = r_underrun;
   assign fifo_rd_rq    = w_rd_rq;
   assign line_val      = w_line_val;
   assign line_last_use = w_last_use;
   // Stale buffer contents stay hidden while no line is held
   assign line_data     = w_line_val ? r_buf[r_head] : '0;

endmodule

// File: doc/inbuf_line_sched.md
# inbuf_line_sched

Parametrised input-buffer line scheduler between the input-data SRAM FIFO and the encoding engine. Reads one data line from the FIFO and presents it for exactly M engine compute cycles. Uses a 2-entry prefetch buffer so consecutive lines reach the engine without bubbles. Runs a programmed number of lines per job, stalls safely on an empty FIFO, and reports done and error events to the main controller.

## Interface
Parameters:
- M_MAX, 128: largest supported M (uses per line); min supported M is 2
- DATA_W, 512: FIFO / line data width
- LINE_CNT_W, 16: width of the per-job line count
- MW (derived), $clog2(M_MAX+1): width of cfg_m
- UW (derived), $clog2(M_MAX): width of the use counter

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset; asynchronous, active-high; clears all state
- eng_rst  in  1  synchronous active-high soft reset from the controller
- start  in  1  job start pulse
- cfg_m  in  MW  uses per line; sampled at start
- cfg_line_num  in  LINE_CNT_W  lines in the job; sampled at start
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- cfg_err  out  1  one-cycle pulse when start is rejected
- underrun_err  out  1  one-cycle pulse when a use arrives with no line
- fifo_rd_rq  out  1  FIFO read request; data returns next cycle
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_data  in  DATA_W  FIFO read data, valid the cycle after fifo_rd_rq
- line_data  out  DATA_W  current line to the engine (head of buffer)
- line_val  out  1  line_data valid
- line_last_use  out  1  line_val and current use is the M-th
- eng_data_used  in  1  engine consumed one compute cycle of the current line

## Operation
- FSM states:
  - IDLE: on start with 2<=cfg_m<=M_MAX and cfg_line_num>=1, latch cfg_m → m_q and cfg_line_num → n_q, clear counters, go to RUN. Otherwise pulse cfg_err and stay in IDLE.
  - RUN: runs the job. When lines_done reaches n_q, go to DONE.
  - DONE: pulse done for one cycle, then return to IDLE.
- busy=1 in RUN and DONE. start is ignored while busy.
- Prefetch buffer: 2-entry FIFO of DATA_W. occ (0..2) is the registered occupancy. inflight is 1 in the cycle after a request.
- fifo_rd_rq = RUN & ~fifo_empty & (lines_req < n_q) & (occ + inflight < 2). It is never asserted when fifo_empty=1.
- Returned data is written at the end of the return cycle. lines_req increments on each request.
- line_val = (occ != 0). line_data = head entry.
- use_cnt (UW bits):
  - On eng_data_used & line_val: if use_cnt == m_q-1, pop the head, set use_cnt=0 and increment lines_done; else use_cnt+1.
  - line_last_use = line_val & (use_cnt == m_q-1).
- eng_data_used with line_val=0: underrun_err pulses the next cycle. No counter changes.
- Pop and write in the same cycle: occ is unchanged and entry order is preserved.
- eng_rst in any state:
  - Return to IDLE and clear occ, inflight, use_cnt, lines_req, lines_done, m_q and n_q.
  - Any FIFO data returning the following cycle is discarded.
  - eng_rst overrides a simultaneous start.
- Reset value of every output is 0, under both rst and eng_rst. The buffer data contents are not reset.

## Timing
- start sampled at edge 0 → RUN in cycle 1.
- First fifo_rd_rq in cycle 1 if the FIFO is not empty. Data is on fifo_rd_data in cycle 2. line_val=1 from cycle 3.
- A second request follows in cycle 2, so the buffer is full by cycle 4.
- Zero-bubble throughput for any M>=2 while the FIFO is non-empty:
  - A pop at edge t frees a slot. The request goes out in t+1 and the line is valid in t+3.
  - The second entry covers cycles t+1..t+2.
- Last pop (lines_done→n_q) at edge t → DONE in t+1 (done=1, busy=1) → IDLE in t+2 (busy=0).
- Empty FIFO: requests stall and line_val drops once the buffer drains. No data is lost. Service resumes 2 cycles after fifo_empty deasserts.

## Test plan
- cfg_m=3, cfg_line_num=2, FIFO preloaded A,B:
  - fifo_rd_rq in cycles 1 and 2, line_val from cycle 3.
  - Engine uses every cycle: line_data=A for 3 cycles, then B for 3 cycles with no gap. line_last_use on the 3rd and 6th uses.
  - done one cycle after the last pop; exactly 2 requests total.
- cfg_m=2, cfg_line_num=8, full FIFO, engine uses every cycle: line_val continuously 1 for 16 cycles, 8 requests, done once.
- FIFO empty for 10 cycles mid-job: no fifo_rd_rq while empty, line_val=0 after the buffer drains, order preserved after refill.
- start with cfg_m=1, and start with cfg_line_num=0: cfg_err pulse each time, busy stays 0, no requests.
- eng_data_used with line_val=0: underrun_err pulse, use_cnt and lines_done unchanged.
- eng_rst in the cycle after a request: data returned next cycle is discarded, all outputs 0, a new start replays from an empty buffer.
